// File: rtl/phys_reg_freelist.sv
// phys_reg_freelist: circular FIFO of free physical registers.
//
// Rename pulls up to two registers per cycle from the head; retire returns up to two
// registers per cycle at the tail. Grants are decided on the pre-edge count only, so
// registers freed in a cycle become allocatable on the following cycle.
//
// Optional feature macro: FREELIST_CHECK_EN
//   defined   : a NUM_PHYS-bit free bitmap catches double frees, overflow frees and
//               duplicate retire pairs; offenders are dropped and set sticky fl_err.
//   undefined : no bitmap, fl_err tied 0, double frees accepted, overflow still dropped.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   alloc_n               registers requested by rename (0..2; 3 acts as 2)
//   alloc_gnt             request granted this cycle (combinational, all-or-nothing)
//   alloc_p_1, alloc_p_2  peek of entry[head], entry[head+1]
//   rt_flag_1/fp_i_1      retire slot 1 free request
//   rt_flag_2/fp_i_2      retire slot 2 free request
//   free_count            registers currently free (0..DEPTH)
//   fl_empty, fl_full     free_count == 0 / free_count == DEPTH
//   fl_err                sticky checker error
module phys_reg_freelist #(
  parameter int unsigned NUM_PHYS = 64,
  parameter int unsigned NUM_ARCH = 32,
  parameter int unsigned PW       = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    alloc_n,
  output logic          alloc_gnt,
  output logic [PW-1:0] alloc_p_1,
  output logic [PW-1:0] alloc_p_2,
  input  logic          rt_flag_1,
  input  logic [PW-1:0] fp_i_1,
  input  logic          rt_flag_2,
  input  logic [PW-1:0] fp_i_2,
  output logic [PW-1:0] free_count,
  output logic          fl_empty,
  output logic          fl_full,
  output logic          fl_err
);

  localparam int unsigned DEPTH = NUM_PHYS - NUM_ARCH;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic [PW-1:0] entry_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [PW-1:0] count_q, count_d;

  logic [1:0]    eff_n;
  logic [PW-1:0] dec;
  logic [PW-1:0] base;
  logic          vld_1, vld_2;
  logic          cand_1, cand_2;
  logic          acc_1, acc_2;
  logic          ovf_1, ovf_2;
  logic          dbl_1, dbl_2, dup;

  always_comb begin
    eff_n     = (alloc_n == 2'd3) ? 2'd2 : alloc_n;
    // Gate with reset so the grant stays low while the list is held in reset.
    alloc_gnt = rst_n && (eff_n != 2'd0) && (PW'(eff_n) <= count_q);
    alloc_p_1 = entry_q[head_q];
    alloc_p_2 = entry_q[head_q + AW'(1)];
    dec       = alloc_gnt ? PW'(eff_n) : '0;
    base      = count_q - dec;
  end

  // p0 backs x0 and is never recycled.
  assign vld_1 = rt_flag_1 && (fp_i_1 != '0);
  assign vld_2 = rt_flag_2 && (fp_i_2 != '0);

`ifdef FREELIST_CHECK_EN
  logic [NUM_PHYS-1:0] map_q, map_d;
  logic                err_q, err_d;

  assign dbl_1 = vld_1 && map_q[fp_i_1];
  assign dbl_2 = vld_2 && map_q[fp_i_2];
  assign dup   = vld_1 && vld_2 && (fp_i_1 == fp_i_2);
`else
  assign dbl_1 = 1'b0;
  assign dbl_2 = 1'b0;
  assign dup   = 1'b0;
`endif

  always_comb begin
    cand_1  = vld_1 && !dbl_1;
    cand_2  = vld_2 && !dbl_2 && !dup;
    // Overflow is judged against the post-allocation count, slot 1 first.
    acc_1   = cand_1 && (base < PW'(DEPTH));
    acc_2   = cand_2 && ((base + PW'(acc_1)) < PW'(DEPTH));
    ovf_1   = cand_1 && !acc_1;
    ovf_2   = cand_2 && !acc_2;
    head_d  = head_q + AW'(dec);
    tail_d  = tail_q + AW'(acc_1) + AW'(acc_2);
    count_d = base + PW'(acc_1) + PW'(acc_2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= PW'(NUM_ARCH + i);
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= PW'(DEPTH);
    end else begin
      if (acc_1) begin
        entry_q[tail_q] <= fp_i_1;
      end
      if (acc_2) begin
        entry_q[tail_q + AW'(acc_1)] <= fp_i_2;
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

`ifdef FREELIST_CHECK_EN
  always_comb begin
    map_d = map_q;
    if (alloc_gnt) begin
      map_d[alloc_p_1] = 1'b0;
      if (eff_n == 2'd2) begin
        map_d[alloc_p_2] = 1'b0;
      end
    end
    if (acc_1) begin
      map_d[fp_i_1] = 1'b1;
    end
    if (acc_2) begin
      map_d[fp_i_2] = 1'b1;
    end
    err_d = err_q | dbl_1 | dbl_2 | dup | ovf_1 | ovf_2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PHYS; i++) begin
        map_q[i] <= (i >= NUM_ARCH);
      end
      err_q <= 1'b0;
    end else begin
      map_q <= map_d;
      err_q <= err_d;
      if (dbl_1)        $display("freelist: double free of p%0d", fp_i_1);
      if (dbl_2)        $display("freelist: double free of p%0d", fp_i_2);
      if (dup && !dbl_2) $display("freelist: duplicate retire pair p%0d", fp_i_2);
      if (ovf_1)        $display("freelist: overflow free of p%0d", fp_i_1);
      if (ovf_2)        $display("freelist: overflow free of p%0d", fp_i_2);
    end
  end

  assign fl_err = err_q;
`else
  assign fl_err = 1'b0;
`endif

  assign free_count = count_q;
  assign fl_empty   = (count_q == '0);
  assign fl_full    = (count_q == PW'(DEPTH));

endmodule
